// File: rtl/regfile_writeback_if.sv
// Bundle of the writeback front end's ALU, load, register-file and hazard-check signals.
// The slave modport is the arbiter side; the master modport is the pipeline/bench side.
interface regfile_writeback_if #(
  parameter int bits            = 32,
  parameter int no_of_registers = 32
);
  localparam int AW = $clog2(no_of_registers);

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [bits-1:0] alu_data;
  logic            alu_stall;

  logic            ld_valid;
  logic [AW-1:0]   ld_rd;
  logic [bits-1:0] ld_data;
  logic            ld_ready;

  logic [AW-1:0]   wb_addr;
  logic [bits-1:0] wb_data;
  logic            wb_en;

  logic [AW-1:0]   chk_rs1;
  logic [AW-1:0]   chk_rs2;
  logic            hazard_rs1;
  logic            hazard_rs2;
  logic            pending;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  chk_rs1, chk_rs2,
    output alu_stall, ld_ready,
    output wb_addr, wb_data, wb_en,
    output hazard_rs1, hazard_rs2, pending
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output chk_rs1, chk_rs2,
    input  alu_stall, ld_ready,
    input  wb_addr, wb_data, wb_en,
    input  hazard_rs1, hazard_rs2, pending
  );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback arbiter: merges ALU results and queued load results onto the register
// file's single write port, with WAW kill, x0 suppression and a starvation stall.
module regfile_writeback #(
  parameter int bits            = 32,
  parameter int no_of_registers = 32,
  parameter int fifo_depth      = 4,
  parameter int max_starve      = 8
) (
  input  logic clk,
  input  logic async_reset,
  regfile_writeback_if.slave bus
);
  localparam int AW = $clog2(no_of_registers);
  localparam int PW = $clog2(fifo_depth);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(max_starve + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(max_starve - 1);

  logic            wb_en_q, wb_en_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [bits-1:0] wb_data_q, wb_data_d;
  logic            alu_stall_q, alu_stall_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   fifo_rd_q   [fifo_depth];
  logic [AW-1:0]   fifo_rd_d   [fifo_depth];
  logic [bits-1:0] fifo_data_q [fifo_depth];
  logic [bits-1:0] fifo_data_d [fifo_depth];
  logic [fifo_depth-1:0] fifo_vld_q, fifo_vld_d;

  logic alu_issue;
  logic fifo_empty;
  logic ld_ready;
  logic ld_accept;
  logic pop;
  logic bypass;
  logic push;
  logic hazard_rs1;
  logic hazard_rs2;

  always_comb begin
    fifo_empty = (count_q == '0);
    ld_ready   = (count_q < CW'(fifo_depth));
    ld_accept  = bus.ld_valid && ld_ready;
    alu_issue  = bus.alu_valid && !alu_stall_q && (bus.alu_rd != '0);
    pop        = !alu_issue && !fifo_empty;
    bypass     = !alu_issue && fifo_empty && ld_accept && (bus.ld_rd != '0);
    // Loads to x0 are consumed here and never occupy a queue slot.
    push       = ld_accept && (bus.ld_rd != '0) && !bypass;
  end

  always_comb begin
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    fifo_vld_d  = fifo_vld_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (alu_issue) begin
      wb_en_d   = 1'b1;
      wb_addr_d = bus.alu_rd;
      wb_data_d = bus.alu_data;
      for (int i = 0; i < fifo_depth; i++) begin
        if (fifo_rd_q[i] == bus.alu_rd) begin
          fifo_vld_d[i] = 1'b0;
        end
      end
    end else if (pop) begin
      wb_en_d = fifo_vld_q[rd_ptr_q];
      if (fifo_vld_q[rd_ptr_q]) begin
        wb_addr_d = fifo_rd_q[rd_ptr_q];
        wb_data_d = fifo_data_q[rd_ptr_q];
      end
      fifo_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (bypass) begin
      wb_en_d   = 1'b1;
      wb_addr_d = bus.ld_rd;
      wb_data_d = bus.ld_data;
    end

    // The push lands after the kill so a same-cycle load to the ALU's rd survives.
    if (push) begin
      fifo_vld_d[wr_ptr_q]  = 1'b1;
      fifo_rd_d[wr_ptr_q]   = bus.ld_rd;
      fifo_data_d[wr_ptr_q] = bus.ld_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q + SW'(1);
    end
    alu_stall_d = (starve_d == STARVE_LIMIT);
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      alu_stall_q <= 1'b0;
      starve_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fifo_vld_q  <= '0;
      for (int i = 0; i < fifo_depth; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      alu_stall_q <= alu_stall_d;
      starve_q    <= starve_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fifo_vld_q  <= fifo_vld_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  always_comb begin
    hazard_rs1 = wb_en_q && (wb_addr_q == bus.chk_rs1);
    hazard_rs2 = wb_en_q && (wb_addr_q == bus.chk_rs2);
    for (int i = 0; i < fifo_depth; i++) begin
      if (fifo_vld_q[i] && (fifo_rd_q[i] == bus.chk_rs1)) begin
        hazard_rs1 = 1'b1;
      end
      if (fifo_vld_q[i] && (fifo_rd_q[i] == bus.chk_rs2)) begin
        hazard_rs2 = 1'b1;
      end
    end
    if (bus.chk_rs1 == '0) begin
      hazard_rs1 = 1'b0;
    end
    if (bus.chk_rs2 == '0) begin
      hazard_rs2 = 1'b0;
    end
  end

  assign bus.wb_en      = wb_en_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.alu_stall  = alu_stall_q;
  assign bus.ld_ready   = ld_ready;
  assign bus.pending    = (count_q != '0);
  assign bus.hazard_rs1 = hazard_rs1;
  assign bus.hazard_rs2 = hazard_rs2;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a vector table for single-beat behaviour plus
// hand sequences for queue-full starvation and mid-operation reset.
module tb_regfile_writeback;
  localparam int BITS = 32;
  localparam int NREG = 32;

  typedef struct {
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        exp_wb_en;
    logic [4:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic        exp_pending;
    logic        exp_ld_ready;
    logic        exp_haz1;
    logic        exp_haz2;
  } vec_t;

  logic clk;
  logic async_reset;
  int   checks;
  int   failures;
  vec_t vecs[$];

  regfile_writeback_if #(.bits(BITS), .no_of_registers(NREG)) bus ();

  regfile_writeback #(
    .bits(BITS), .no_of_registers(NREG), .fifo_depth(4), .max_starve(8)
  ) dut (
    .clk(clk),
    .async_reset(async_reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                               input logic [4:0] c1, input logic [4:0] c2);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ld;
    bus.chk_rs1   = c1;
    bus.chk_rs2   = c2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] c1, input logic [4:0] c2,
                         input logic en, input logic [4:0] addr, input logic [31:0] data,
                         input logic pend, input logic rdy, input logic h1, input logic h2);
    vec_t v;
    v.alu_valid = av;  v.alu_rd = ard;  v.alu_data = ad;
    v.ld_valid  = lv;  v.ld_rd  = lrd;  v.ld_data  = ld;
    v.chk_rs1   = c1;  v.chk_rs2 = c2;
    v.exp_wb_en = en;  v.exp_wb_addr = addr;  v.exp_wb_data = data;
    v.exp_pending = pend;  v.exp_ld_ready = rdy;
    v.exp_haz1 = h1;  v.exp_haz2 = h2;
    vecs.push_back(v);
  endtask

  initial begin
    logic [4:0] lrd;
    checks   = 0;
    failures = 0;
    async_reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Each row: inputs for one cycle, then outputs observed just after that cycle's edge.
    //       alu v rd  data           ld v rd  data           chk1   chk2   en   addr   data           pnd  rdy  h1   h2
    add_vec(1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,    5'd5,  5'd0, 1'b1, 5'd5,  32'h1234, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd5,  5'd7, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 5'd3,  32'h3333, 1'b1, 5'd7,  32'hAA,   5'd3,  5'd7, 1'b1, 5'd3,  32'h3333, 1'b1, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd7,  5'd3, 1'b1, 5'd7,  32'hAA,   1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd7,  5'd0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 5'd4,  32'h44,   1'b1, 5'd9,  32'h99,   5'd9,  5'd4, 1'b1, 5'd4,  32'h44,   1'b1, 1'b1, 1'b1, 1'b1);
    add_vec(1'b1, 5'd9,  32'h900,  1'b0, 5'd0,  32'h0,    5'd9,  5'd4, 1'b1, 5'd9,  32'h900,  1'b1, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd9,  5'd0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd9,  5'd9, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 5'd0,  32'hDEAD, 1'b1, 5'd0,  32'hBEEF, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 5'd0,  32'hDEAD, 1'b0, 5'd0,  32'h0,    5'd0,  5'd0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hBEEF, 5'd0,  5'd0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 32'h1200, 5'd12, 5'd0, 1'b1, 5'd12, 32'h1200, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd12, 5'd0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 5'd6,  32'h60,   1'b1, 5'd6,  32'h66,   5'd6,  5'd5, 1'b1, 5'd6,  32'h60,   1'b1, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd6,  5'd0, 1'b1, 5'd6,  32'h66,   1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd6,  5'd0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0);

    #12;
    checkOutput("reset wb_en",     32'(bus.wb_en),     32'd0);
    checkOutput("reset wb_addr",   32'(bus.wb_addr),   32'd0);
    checkOutput("reset wb_data",   bus.wb_data,        32'd0);
    checkOutput("reset alu_stall", 32'(bus.alu_stall), 32'd0);
    checkOutput("reset ld_ready",  32'(bus.ld_ready),  32'd1);
    checkOutput("reset pending",   32'(bus.pending),   32'd0);
    @(negedge clk);
    async_reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].alu_valid, vecs[i].alu_rd, vecs[i].alu_data,
                    vecs[i].ld_valid, vecs[i].ld_rd, vecs[i].ld_data,
                    vecs[i].chk_rs1, vecs[i].chk_rs2);
      step();
      checkOutput($sformatf("v%0d wb_en", i), 32'(bus.wb_en), 32'(vecs[i].exp_wb_en));
      if (vecs[i].exp_wb_en) begin
        checkOutput($sformatf("v%0d wb_addr", i), 32'(bus.wb_addr), 32'(vecs[i].exp_wb_addr));
        checkOutput($sformatf("v%0d wb_data", i), bus.wb_data, vecs[i].exp_wb_data);
      end
      checkOutput($sformatf("v%0d pending", i),    32'(bus.pending),    32'(vecs[i].exp_pending));
      checkOutput($sformatf("v%0d ld_ready", i),   32'(bus.ld_ready),   32'(vecs[i].exp_ld_ready));
      checkOutput($sformatf("v%0d alu_stall", i),  32'(bus.alu_stall),  32'd0);
      checkOutput($sformatf("v%0d hazard_rs1", i), 32'(bus.hazard_rs1), 32'(vecs[i].exp_haz1));
      checkOutput($sformatf("v%0d hazard_rs2", i), 32'(bus.hazard_rs2), 32'(vecs[i].exp_haz2));
    end

    // ALU busy every cycle while five loads are offered; the queue fills and starves.
    for (int c = 0; c < 8; c++) begin
      lrd = (c < 4) ? 5'(20 + c) : 5'd24;
      applyStimulus(1'b1, 5'd1, 32'h1000 + 32'(c), 1'b1, lrd, 32'hA000 + 32'(lrd), 5'd20, 5'd0);
      step();
      checkOutput($sformatf("starve c%0d wb_en", c),      32'(bus.wb_en),      32'd1);
      checkOutput($sformatf("starve c%0d wb_addr", c),    32'(bus.wb_addr),    32'd1);
      checkOutput($sformatf("starve c%0d wb_data", c),    bus.wb_data,         32'h1000 + 32'(c));
      checkOutput($sformatf("starve c%0d alu_stall", c),  32'(bus.alu_stall),  32'(c == 7));
      checkOutput($sformatf("starve c%0d ld_ready", c),   32'(bus.ld_ready),   32'(c < 3));
      checkOutput($sformatf("starve c%0d hazard_rs1", c), 32'(bus.hazard_rs1), 32'd1);
    end
    applyStimulus(1'b1, 5'd1, 32'hFFFF, 1'b1, 5'd24, 32'hA018, 5'd20, 5'd0);
    step();
    checkOutput("stall pop wb_en",     32'(bus.wb_en),     32'd1);
    checkOutput("stall pop wb_addr",   32'(bus.wb_addr),   32'd20);
    checkOutput("stall pop wb_data",   bus.wb_data,        32'hA014);
    checkOutput("stall pop alu_stall", 32'(bus.alu_stall), 32'd0);
    checkOutput("stall pop ld_ready",  32'(bus.ld_ready),  32'd1);
    applyStimulus(1'b1, 5'd1, 32'h1009, 1'b1, 5'd24, 32'hA018, 5'd0, 5'd0);
    step();
    checkOutput("refill wb_addr",  32'(bus.wb_addr),  32'd1);
    checkOutput("refill wb_data",  bus.wb_data,       32'h1009);
    checkOutput("refill ld_ready", 32'(bus.ld_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      step();
      checkOutput($sformatf("drain k%0d wb_en", k),   32'(bus.wb_en),   32'd1);
      checkOutput($sformatf("drain k%0d wb_addr", k), 32'(bus.wb_addr), 32'(21 + k));
      checkOutput($sformatf("drain k%0d wb_data", k), bus.wb_data,      32'hA000 + 32'(21 + k));
      checkOutput($sformatf("drain k%0d pending", k), 32'(bus.pending), 32'(k < 3));
    end

    // Two loads queued behind ALU traffic, then reset lands mid-cycle.
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd17, 32'h1717, 5'd17, 5'd18);
    step();
    applyStimulus(1'b1, 5'd2, 32'h23, 1'b1, 5'd18, 32'h1818, 5'd17, 5'd18);
    step();
    checkOutput("prereset wb_en",      32'(bus.wb_en),      32'd1);
    checkOutput("prereset pending",    32'(bus.pending),    32'd1);
    checkOutput("prereset hazard_rs1", 32'(bus.hazard_rs1), 32'd1);
    checkOutput("prereset hazard_rs2", 32'(bus.hazard_rs2), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd17, 5'd18);
    #3;
    async_reset = 1'b0;
    #1;
    checkOutput("midreset wb_en",      32'(bus.wb_en),      32'd0);
    checkOutput("midreset wb_data",    bus.wb_data,         32'd0);
    checkOutput("midreset pending",    32'(bus.pending),    32'd0);
    checkOutput("midreset ld_ready",   32'(bus.ld_ready),   32'd1);
    checkOutput("midreset hazard_rs1", 32'(bus.hazard_rs1), 32'd0);
    step();
    step();
    @(negedge clk);
    async_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("postreset k%0d wb_en", k),      32'(bus.wb_en),      32'd0);
      checkOutput($sformatf("postreset k%0d pending", k),    32'(bus.pending),    32'd0);
      checkOutput($sformatf("postreset k%0d hazard_rs1", k), 32'(bus.hazard_rs1), 32'd0);
      checkOutput($sformatf("postreset k%0d hazard_rs2", k), 32'(bus.hazard_rs2), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
